// File: rtl/subneg_pkg.sv
// Shared types for the SUBNEG program loader: control FSM states,
// WRITE sub-phases, UART receiver states and the length-byte decode.
package subneg_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LEN,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_DONE
  } ld_state_t;

  typedef enum logic [2:0] {
    W0,
    W1,
    W2,
    W3,
    W4
  } wr_phase_t;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  localparam int unsigned UART_CNT_W = 12;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] len_decode(input logic [7:0] b);
    return (b == 8'd0) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/subneg_uart_rx.sv
// 8N1 UART receiver, LSB first. Synchronizes rx, validates the start bit
// at half a bit period, samples eight data bits and the stop bit.
module subneg_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       start_ok,
  output logic       byte_valid,
  output logic       frame_err_pulse,
  output logic [7:0] data
);
  import subneg_pkg::*;

  localparam logic [UART_CNT_W-1:0] FULL_M1 = UART_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_CNT_W-1:0] HALF_M1 = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                  rx_meta, rx_sync, rx_prev;
  uart_state_t           state, state_d;
  logic [UART_CNT_W-1:0] cnt, cnt_d;
  logic [2:0]            bit_idx, bit_idx_d;
  logic [7:0]            shreg, shreg_d;
  logic                  start_ok_d, byte_valid_d, frame_err_d;
  logic [7:0]            data_d;

  // Two-flop synchronizer plus one extra stage for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state, bit timer, shift register and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= U_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      start_ok        <= 1'b0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      data            <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      bit_idx         <= bit_idx_d;
      shreg           <= shreg_d;
      start_ok        <= start_ok_d;
      byte_valid      <= byte_valid_d;
      frame_err_pulse <= frame_err_d;
      data            <= data_d;
    end
  end

  // Next-state: start validation, mid-bit sampling, stop-bit check.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt + 1'b1;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    start_ok_d   = 1'b0;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    data_d       = data;
    case (state)
      U_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_prev && !rx_sync) state_d = U_START;
      end
      U_START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = U_IDLE;
          end else begin
            state_d    = U_DATA;
            start_ok_d = 1'b1;
          end
        end
      end
      U_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d     = '0;
          shreg_d   = {rx_sync, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = U_STOP;
        end
      end
      U_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = U_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            data_d       = shreg;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

endmodule

// File: rtl/subneg_loader.sv
// Serial program loader for the SUBNEG core: receives a length-prefixed
// image over UART, writes it to SRAM through the address latch, then
// raises run and releases the bus.
module subneg_loader #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       halt,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       run,
  output logic       busy,
  output logic       frame_err
);
  import subneg_pkg::*;

  logic       start_ok, byte_valid, frame_err_pulse;
  logic [7:0] rx_data;

  ld_state_t  state, state_d;
  wr_phase_t  phase, phase_d;
  logic [7:0] addr, addr_d;
  logic [8:0] remaining, remaining_d;
  logic [7:0] hold, hold_d;

  logic       latch_d, we_n_d, bus_oe_d, run_d, busy_d, frame_err_d;
  logic [7:0] bus_d;

  subneg_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .start_ok       (start_ok),
    .byte_valid     (byte_valid),
    .frame_err_pulse(frame_err_pulse),
    .data           (rx_data)
  );

  // Control state, counters and all registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_WAIT_LEN;
      phase         <= W0;
      addr          <= '0;
      remaining     <= '0;
      hold          <= '0;
      mem_latch_clk <= 1'b0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      bus_out       <= '0;
      bus_oe        <= 1'b1;
      run           <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_d;
      phase         <= phase_d;
      addr          <= addr_d;
      remaining     <= remaining_d;
      hold          <= hold_d;
      mem_latch_clk <= latch_d;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= we_n_d;
      bus_out       <= bus_d;
      bus_oe        <= bus_oe_d;
      run           <= run_d;
      busy          <= busy_d;
      frame_err     <= frame_err_d;
    end
  end

  // Next-state and counter updates; halt overrides every state.
  always_comb begin
    state_d     = state;
    phase_d     = phase;
    addr_d      = addr;
    remaining_d = remaining;
    hold_d      = hold;
    busy_d      = busy;
    frame_err_d = frame_err | frame_err_pulse;
    if (halt) begin
      state_d     = ST_WAIT_LEN;
      phase_d     = W0;
      busy_d      = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      case (state)
        ST_WAIT_LEN: begin
          addr_d = '0;
          if (start_ok) busy_d = 1'b1;
          if (byte_valid) begin
            remaining_d = len_decode(rx_data);
            state_d     = ST_WAIT_DATA;
            busy_d      = 1'b1;
          end
        end
        ST_WAIT_DATA: begin
          if (byte_valid) begin
            hold_d  = rx_data;
            phase_d = W0;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          case (phase)
            W0: phase_d = W1;
            W1: phase_d = W2;
            W2: phase_d = W3;
            W3: phase_d = W4;
            W4: begin
              addr_d      = addr + 8'd1;
              remaining_d = remaining - 9'd1;
              phase_d     = W0;
              if (remaining == 9'd1) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
              end else begin
                state_d = ST_WAIT_DATA;
              end
            end
            default: phase_d = W0;
          endcase
        end
        ST_DONE: busy_d = 1'b0;
        default: state_d = ST_WAIT_LEN;
      endcase
    end
  end

  // Pins are decoded from the next state so the registered outputs line up
  // with the phase they belong to; any exit from WRITE (including halt)
  // therefore lands with the latch low and write enable released.
  always_comb begin
    latch_d = 1'b0;
    we_n_d  = 1'b1;
    bus_d   = '0;
    if (state_d == ST_WRITE) begin
      case (phase_d)
        W0: bus_d = addr_d;
        W1: begin
          bus_d   = addr_d;
          latch_d = 1'b1;
        end
        W2: begin
          bus_d   = hold_d;
          latch_d = 1'b1;
        end
        W3: begin
          bus_d   = hold_d;
          latch_d = 1'b1;
          we_n_d  = 1'b0;
        end
        W4: bus_d = hold_d;
        default: bus_d = '0;
      endcase
    end
    run_d    = (state_d == ST_DONE);
    bus_oe_d = ~run_d;
  end

endmodule
